// File: rtl/teclado_matrix_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : teclado_matrix_scan_if
// Purpose  : Key-event valid/ready channel between the keypad scanner and
//            its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface teclado_matrix_scan_if #(
    parameter int CW = 4
);
    logic [CW-1:0] key_code;
    logic          key_valid;
    logic          key_ready;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready
    );
endinterface
`default_nettype wire

// File: rtl/teclado_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module   : teclado_matrix_scan
// Purpose  : Parametrised active-low keypad matrix scanner with frame debounce,
//            ghost rejection and a valid/ready key-event output.
//            Define KEY_REPEAT_EN to enable auto-repeat while a key is held.
// Revision : 1.0 - initial release
// ============================================================================
module teclado_matrix_scan #(
    parameter int N_ROWS          = 4,
    parameter int N_COLS          = 4,
    parameter int SCAN_DIV        = 50,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_RATE     = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [N_ROWS-1:0] filas,
    output logic      [N_COLS-1:0] columnas,
    teclado_matrix_scan_if.master  key_if,
    output logic                   key_down,
    output logic                   multi_key,
    output logic                   overrun
);

    localparam int c_CW     = $clog2(N_ROWS * N_COLS);
    localparam int c_DW     = $clog2(SCAN_DIV);
    localparam int c_CIW    = $clog2(N_COLS);
    localparam int c_RW     = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int c_FMAX0  = (DEBOUNCE_FRAMES > REPEAT_DELAY) ? DEBOUNCE_FRAMES : REPEAT_DELAY;
    localparam int c_FMAX   = (c_FMAX0 > REPEAT_RATE) ? c_FMAX0 : REPEAT_RATE;
    localparam int c_FW     = $clog2(c_FMAX + 1);

    localparam logic [c_DW-1:0]   c_DWELL_LAST = c_DW'(SCAN_DIV - 1);
    localparam logic [c_CIW-1:0]  c_COL_LAST   = c_CIW'(N_COLS - 1);
    localparam logic [N_COLS-1:0] c_COLS_RST   = {{(N_COLS-1){1'b1}}, 1'b0};
    localparam logic [c_FW-1:0]   c_DF         = c_FW'(DEBOUNCE_FRAMES);

    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_S_PRESSED  = 2'd2;
    localparam logic [1:0] c_S_RELEASE  = 2'd3;

    logic [N_ROWS-1:0] r_filas_m;
    logic [N_ROWS-1:0] r_filas_s;
    logic [c_DW-1:0]   r_dwell;
    logic [c_CIW-1:0]  r_col;
    logic [N_COLS-1:0] r_columnas;
    logic [1:0]        r_nclos;
    logic [c_CW-1:0]   r_code;
    logic [1:0]        r_state;
    logic [c_CW-1:0]   r_cand;
    logic [c_FW-1:0]   r_cnt;
    logic              r_key_valid;
    logic [c_CW-1:0]   r_key_code;
    logic              r_overrun;
    logic              r_multi;

    logic              w_dwell_end;
    logic              w_last_col;
    logic              w_frame_end;
    logic [1:0]        w_col_cnt;
    logic [c_RW-1:0]   w_col_row;
    logic [c_CW-1:0]   w_sample_code;
    logic [1:0]        w_tot_cnt;
    logic [c_CW-1:0]   w_tot_code;
    logic              w_none;
    logic              w_single;
    logic              w_multi;
    logic [1:0]        w_state_nxt;
    logic [c_CW-1:0]   w_cand_nxt;
    logic [c_FW-1:0]   w_cnt_nxt;
    logic [c_FW-1:0]   w_cnt_inc;
    logic              w_emit;
    logic              w_emit_all;
    logic              w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_filas_m <= '1;
            r_filas_s <= '1;
        end else begin
            r_filas_m <= filas;
            r_filas_s <= r_filas_m;
        end
    end

    assign w_dwell_end = (r_dwell == c_DWELL_LAST);
    assign w_last_col  = (r_col == c_COL_LAST);
    assign w_frame_end = w_dwell_end & w_last_col;

    // Column drive is a rotating zero kept in step with the column index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell    <= '0;
            r_col      <= '0;
            r_columnas <= c_COLS_RST;
        end else if (w_dwell_end) begin
            r_dwell    <= '0;
            r_col      <= w_last_col ? '0 : r_col + 1'b1;
            r_columnas <= w_last_col ? c_COLS_RST : {r_columnas[N_COLS-2:0], 1'b1};
        end else begin
            r_dwell    <= r_dwell + 1'b1;
        end
    end

    assign columnas = r_columnas;

    always_comb begin
        w_col_cnt = 2'd0;
        w_col_row = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (!r_filas_s[r]) begin
                if (w_col_cnt != 2'd2) w_col_cnt = w_col_cnt + 2'd1;
                w_col_row = c_RW'(r);
            end
        end
    end

    assign w_sample_code = c_CW'(int'(w_col_row) * N_COLS + int'(r_col));

    // Closure count saturates at 2: anything beyond one closure is MULTI.
    always_comb begin
        w_tot_cnt  = r_nclos;
        w_tot_code = r_code;
        if (w_dwell_end && (w_col_cnt != 2'd0)) begin
            if ((r_nclos == 2'd0) && (w_col_cnt == 2'd1)) begin
                w_tot_cnt  = 2'd1;
                w_tot_code = w_sample_code;
            end else begin
                w_tot_cnt  = 2'd2;
            end
        end
    end

    assign w_none   = (w_tot_cnt == 2'd0);
    assign w_single = (w_tot_cnt == 2'd1);
    assign w_multi  = (w_tot_cnt == 2'd2);

    always_ff @(posedge clk) begin
        if (rst || w_frame_end) begin
            r_nclos <= 2'd0;
            r_code  <= '0;
        end else if (w_dwell_end) begin
            r_nclos <= w_tot_cnt;
            r_code  <= w_tot_code;
        end
    end

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_emit      = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_single) begin
                        w_cand_nxt = w_tot_code;
                        if (DEBOUNCE_FRAMES == 1) begin
                            w_state_nxt = c_S_PRESSED;
                            w_cnt_nxt   = '0;
                            w_emit      = 1'b1;
                        end else begin
                            w_state_nxt = c_S_DEBOUNCE;
                            w_cnt_nxt   = c_FW'(1);
                        end
                    end
                end
                c_S_DEBOUNCE: begin
                    if (w_single && (w_tot_code == r_cand)) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_DF) begin
                            w_state_nxt = c_S_PRESSED;
                            w_cnt_nxt   = '0;
                            w_emit      = 1'b1;
                        end
                    end else begin
                        w_state_nxt = c_S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                c_S_PRESSED: begin
                    if (w_none) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            w_state_nxt = c_S_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = c_S_RELEASE;
                            w_cnt_nxt   = c_FW'(1);
                        end
                    end else if (w_single && (w_tot_code != r_cand)) begin
                        w_cand_nxt = w_tot_code;
                        if (DEBOUNCE_FRAMES == 1) begin
                            w_emit = 1'b1;
                        end else begin
                            w_state_nxt = c_S_DEBOUNCE;
                            w_cnt_nxt   = c_FW'(1);
                        end
                    end
                end
                c_S_RELEASE: begin
                    if (w_none) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_DF) begin
                            w_state_nxt = c_S_IDLE;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_state_nxt = c_S_PRESSED;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = c_S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam logic [c_FW-1:0] c_RDELAY = c_FW'(REPEAT_DELAY);
    localparam logic [c_FW-1:0] c_RRATE  = c_FW'(REPEAT_RATE);

    logic [c_FW-1:0] r_rep;
    logic            r_rep_late;
    logic [c_FW-1:0] w_rep_nxt;
    logic [c_FW-1:0] w_rep_inc;
    logic            w_rep_late_nxt;
    logic            w_rep_emit;

    assign w_rep_inc = r_rep + 1'b1;

    // r_rep_late selects the slower first interval until the first repeat.
    always_comb begin
        w_rep_nxt      = r_rep;
        w_rep_late_nxt = r_rep_late;
        w_rep_emit     = 1'b0;
        if ((r_state != c_S_PRESSED) || (w_state_nxt != c_S_PRESSED)) begin
            w_rep_nxt      = '0;
            w_rep_late_nxt = 1'b0;
        end else if (w_frame_end) begin
            if (w_single && (w_tot_code == r_cand)) begin
                if (w_rep_inc == (r_rep_late ? c_RRATE : c_RDELAY)) begin
                    w_rep_emit     = 1'b1;
                    w_rep_nxt      = '0;
                    w_rep_late_nxt = 1'b1;
                end else begin
                    w_rep_nxt      = w_rep_inc;
                end
            end else begin
                w_rep_nxt      = '0;
                w_rep_late_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep      <= '0;
            r_rep_late <= 1'b0;
        end else begin
            r_rep      <= w_rep_nxt;
            r_rep_late <= w_rep_late_nxt;
        end
    end

    assign w_emit_all = w_emit | w_rep_emit;
`else
    assign w_emit_all = w_emit;
`endif

    assign w_accept = r_key_valid & key_if.key_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_overrun   <= 1'b0;
            r_multi     <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            r_multi   <= w_frame_end & w_multi;
            if (w_emit_all) begin
                if (!r_key_valid || w_accept) begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= w_tot_code;
                end else begin
                    r_overrun   <= 1'b1;
                end
            end else if (w_accept) begin
                r_key_valid <= 1'b0;
            end
        end
    end

    assign key_if.key_valid = r_key_valid;
    assign key_if.key_code  = r_key_code;
    assign key_down         = (r_state == c_S_PRESSED) || (r_state == c_S_RELEASE);
    assign multi_key        = r_multi;
    assign overrun          = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_teclado_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_teclado_matrix_scan
// Purpose  : Directed self-checking bench for teclado_matrix_scan on a 4x4
//            matrix, SCAN_DIV=4 (16-clock frames), DEBOUNCE_FRAMES=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_teclado_matrix_scan;

`ifdef KEY_REPEAT_EN
    localparam int c_EXP_SINGLE = 3;
`else
    localparam int c_EXP_SINGLE = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  filas;
    logic [3:0]  columnas;
    logic        key_down;
    logic        multi_key;
    logic        overrun;
    logic [15:0] keys = '0;
    logic [3:0]  phase;

    int checks = 0;
    int errors = 0;

    int          ev_n, ev_first, ev_last, vld_first, mk_n, ov_n, dn_n, cyc;
    logic [3:0]  ev_code;

    teclado_matrix_scan_if #(.CW(4)) kif ();

    teclado_matrix_scan #(
        .N_ROWS          (4),
        .N_COLS          (4),
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3),
        .REPEAT_DELAY    (4),
        .REPEAT_RATE     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .filas     (filas),
        .columnas  (columnas),
        .key_if    (kif),
        .key_down  (key_down),
        .multi_key (multi_key),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) filas[r] = ~|(keys[r*4 +: 4] & ~columnas);
    end

    // Frame phase reference: phase 0 is the first clock after reset.
    always @(posedge clk) begin
        if (rst) phase <= 4'd0;
        else     phase <= phase + 4'd1;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_counts();
        ev_n = 0; ev_first = -1; ev_last = -1; vld_first = -1;
        mk_n = 0; ov_n = 0; dn_n = 0; cyc = 0; ev_code = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (kif.key_valid && vld_first < 0) vld_first = cyc;
            if (kif.key_valid && kif.key_ready) begin
                ev_n++;
                if (ev_first < 0) ev_first = cyc;
                ev_last = cyc;
                ev_code = kif.key_code;
            end
            if (multi_key) mk_n++;
            if (overrun)   ov_n++;
            if (key_down)  dn_n++;
        end
    endtask

    task automatic align();
        @(negedge clk);
        for (int i = 0; i < 16 && phase != 4'd0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        keys = '0;
        kif.key_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (columnas !== 4'b1110) begin errors++; $display("FAIL reset_columnas: got %b expected %b", columnas, 4'b1110); end
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", kif.key_valid); end
        checks++; if (kif.key_code !== 4'd0) begin errors++; $display("FAIL reset_key_code: got %0d expected 0", kif.key_code); end
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL reset_key_down: got %b expected 0", key_down); end
        checks++; if (multi_key !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses: got multi=%b ovr=%b expected 0 0", multi_key, overrun); end
        repeat (3) @(negedge clk);
        checks++; if (columnas !== 4'b1110) begin errors++; $display("FAIL scan_dwell_end: got %b expected %b", columnas, 4'b1110); end
        @(negedge clk);
        checks++; if (columnas !== 4'b1101) begin errors++; $display("FAIL scan_col1: got %b expected %b", columnas, 4'b1101); end
        repeat (8) @(negedge clk);
        checks++; if (columnas !== 4'b0111) begin errors++; $display("FAIL scan_col3: got %b expected %b", columnas, 4'b0111); end
        repeat (4) @(negedge clk);
        checks++; if (columnas !== 4'b1110) begin errors++; $display("FAIL scan_wrap: got %b expected %b", columnas, 4'b1110); end
    endtask

    task automatic test_single_press();
        kif.key_ready = 1'b1;
        align();
        clear_counts();
        keys[9] = 1'b1;
        run(160);
        checks++; if (ev_n !== c_EXP_SINGLE) begin errors++; $display("FAIL single_events: got %0d expected %0d", ev_n, c_EXP_SINGLE); end
        checks++; if (ev_first !== 48) begin errors++; $display("FAIL single_latency: got %0d expected 48", ev_first); end
        checks++; if (ev_code !== 4'd9) begin errors++; $display("FAIL single_code: got %0d expected 9", ev_code); end
        checks++; if (key_down !== 1'b1 || mk_n !== 0) begin errors++; $display("FAIL single_held: got down=%b multi=%0d expected 1 0", key_down, mk_n); end
        keys = '0;
        clear_counts();
        run(47);
        checks++; if (key_down !== 1'b1 || ev_n !== 0) begin errors++; $display("FAIL release_hold: got down=%b events=%0d expected 1 0", key_down, ev_n); end
        run(1);
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL release_done: got %b expected 0", key_down); end
    endtask

    task automatic test_bounce();
        align();
        clear_counts();
        for (int f = 0; f < 6; f++) begin
            keys[3] = (f % 2 == 0);
            run(16);
        end
        keys = '0;
        run(64);
        checks++; if (ev_n !== 0 || vld_first !== -1) begin errors++; $display("FAIL bounce_events: got %0d valid_at=%0d expected 0 -1", ev_n, vld_first); end
        checks++; if (dn_n !== 0) begin errors++; $display("FAIL bounce_key_down: got %0d high cycles expected 0", dn_n); end
    endtask

    task automatic test_ghosting();
        align();
        clear_counts();
        keys[0] = 1'b1;
        keys[4] = 1'b1;
        run(80);
        keys = '0;
        run(4);
        checks++; if (mk_n !== 5) begin errors++; $display("FAIL ghost_multi: got %0d pulses expected 5", mk_n); end
        checks++; if (ev_n !== 0 || dn_n !== 0) begin errors++; $display("FAIL ghost_event: got events=%0d down=%0d expected 0 0", ev_n, dn_n); end
        run(64);
    endtask

    task automatic test_backpressure();
        kif.key_ready = 1'b0;
        align();
        clear_counts();
        keys[5] = 1'b1;
        run(64);
        checks++; if (vld_first !== 48) begin errors++; $display("FAIL bp_first_valid: got %0d expected 48", vld_first); end
        checks++; if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd5) begin errors++; $display("FAIL bp_hold: got valid=%b code=%0d expected 1 5", kif.key_valid, kif.key_code); end
        keys = '0;
        run(80);
        clear_counts();
        keys[10] = 1'b1;
        run(64);
        checks++; if (ov_n !== 1) begin errors++; $display("FAIL bp_overrun: got %0d pulses expected 1", ov_n); end
        checks++; if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd5) begin errors++; $display("FAIL bp_keep_first: got valid=%b code=%0d expected 1 5", kif.key_valid, kif.key_code); end
        kif.key_ready = 1'b1;
        @(negedge clk);
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b expected 0", kif.key_valid); end
        keys = '0;
        run(80);
    endtask

    task automatic test_reset_mid();
        kif.key_ready = 1'b1;
        align();
        clear_counts();
        keys[15] = 1'b1;
        run(34);
        checks++; if (ev_n !== 0 || key_down !== 1'b0) begin errors++; $display("FAIL rmid_pre: got events=%0d down=%b expected 0 0", ev_n, key_down); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (columnas !== 4'b1110 || kif.key_valid !== 1'b0 || kif.key_code !== 4'd0 || key_down !== 1'b0) begin
            errors++;
            $display("FAIL rmid_reset: got cols=%b valid=%b code=%0d down=%b expected 1110 0 0 0", columnas, kif.key_valid, kif.key_code, key_down);
        end
        clear_counts();
        run(64);
        checks++; if (ev_first !== 48 || ev_code !== 4'd15) begin errors++; $display("FAIL rmid_redebounce: got at=%0d code=%0d expected 48 15", ev_first, ev_code); end
        keys = '0;
        run(80);
    endtask

`ifdef KEY_REPEAT_EN
    task automatic test_repeat();
        kif.key_ready = 1'b1;
        align();
        clear_counts();
        keys[0] = 1'b1;
        run(240);
        checks++; if (ev_n !== 6) begin errors++; $display("FAIL repeat_count: got %0d expected 6", ev_n); end
        checks++; if (ev_first !== 48 || ev_last !== 240) begin errors++; $display("FAIL repeat_times: got first=%0d last=%0d expected 48 240", ev_first, ev_last); end
        keys = '0;
        run(80);
    endtask
`endif

    initial begin
        kif.key_ready = 1'b1;
        test_reset();
        test_single_press();
        test_bounce();
        test_ghosting();
        test_backpressure();
        test_reset_mid();
`ifdef KEY_REPEAT_EN
        test_repeat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
